// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// data_mem_responder : multi-cycle word-addressed data memory for the MEM stage
// Revision: 1.0
// ============================================================================
module data_mem_responder #(
  parameter int          DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEMread,
  input  logic        MEMwrite,
  input  logic [31:0] address,
  input  logic [31:0] data,
  output logic [31:0] MEM_result,
  output logic        ready,
  output logic        addr_err
);

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             is_wr_q, is_wr_d;
  logic             is_rd_q, is_rd_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic [31:0]      mem_result_q, mem_result_d;
  logic             mem_we;

  logic [31:0] mem [DEPTH];

  logic        req;
  logic [31:0] word_idx;
  logic        out_of_range;

  assign req          = MEMread | MEMwrite;
  assign word_idx     = (address - BASE_ADDR) >> 2;
  assign out_of_range = (address < BASE_ADDR) || (word_idx >= 32'(DEPTH));
  assign addr_err     = req & out_of_range;
  assign MEM_result   = mem_result_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_wr_d      = is_wr_q;
    is_rd_d      = is_rd_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    mem_result_d = mem_result_q;
    mem_we       = 1'b0;
    ready        = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = ~req;
        if (req) begin
          state_d = S_ACCESS;
          cnt_d   = 4'd0;
          is_wr_d = MEMwrite;
          is_rd_d = MEMread;
          idx_d   = word_idx[IDX_W-1:0];
          wdata_d = data;
          err_d   = out_of_range;
        end
      end
      S_ACCESS: begin
        if (!req) begin
          // Initiator withdrew the request (flush): nothing is committed.
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          if (is_wr_q) begin
            mem_we = ~err_q;
            if (is_rd_q) begin
              mem_result_d = 32'd0;
            end
          end else if (is_rd_q) begin
            mem_result_d = err_q ? 32'd0 : mem[idx_q];
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        ready   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      is_wr_q      <= 1'b0;
      is_rd_q      <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= 32'd0;
      err_q        <= 1'b0;
      mem_result_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_wr_q      <= is_wr_d;
      is_rd_q      <= is_rd_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      mem_result_q <= mem_result_d;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// Directed self-checking bench for data_mem_responder (DEPTH=64, BASE=1024, WAIT=4).
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        MEMread;
  logic        MEMwrite;
  logic [31:0] address;
  logic [31:0] data;
  logic [31:0] MEM_result;
  logic        ready;
  logic        addr_err;

  int total;
  int bad;

  data_mem_responder #(
    .DEPTH      (64),
    .BASE_ADDR  (32'd1024),
    .WAIT_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .MEMread   (MEMread),
    .MEMwrite  (MEMwrite),
    .address   (address),
    .data      (data),
    .MEM_result(MEM_result),
    .ready     (ready),
    .addr_err  (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge: presents the request, counts not-ready cycles until
  // ready, captures outputs, then steps to the next negedge and optionally drops req.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input bit release_req,
                        output int lows, output logic [31:0] res, output logic err);
    MEMread  = rd;
    MEMwrite = wr;
    address  = a;
    data     = d;
    #1;
    err  = addr_err;
    lows = 0;
    while (!ready && lows < 40) begin
      lows++;
      @(negedge clk);
      #1;
    end
    res = MEM_result;
    @(negedge clk);
    if (release_req) begin
      MEMread  = 1'b0;
      MEMwrite = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; MEMread = 1'b1; MEMwrite = 1'b0; address = 32'd1024; data = 32'd0;
    #2;
    total++;
    if (MEM_result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=%h", MEM_result, 32'd0); end
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready_req got=%b exp=0", ready); end
    MEMread = 1'b0;
    #1;
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready_noreq got=%b exp=1", ready); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", ready); end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lows; logic [31:0] res; logic err;
    access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b1, lows, res, err);
    total++;
    if (lows !== 5) begin bad++; $display("FAIL wr_latency got=%0d exp=5", lows); end
    @(negedge clk);
    access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, lows, res, err);
    total++;
    if (lows !== 5) begin bad++; $display("FAIL rd_latency got=%0d exp=5", lows); end
    total++;
    if (res !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=DEADBEEF", res); end
    #1;
    total++;
    if (MEM_result !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_hold got=%h exp=DEADBEEF", MEM_result); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lows; logic [31:0] res; logic err;
    access(1'b0, 1'b1, 32'd1032, 32'h22, 1'b1, lows, res, err);
    @(negedge clk);
    access(1'b0, 1'b1, 32'd1024, 32'h11, 1'b0, lows, res, err);
    total++;
    if (lows !== 5) begin bad++; $display("FAIL b2b_st_latency got=%0d exp=5", lows); end
    #1;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL b2b_gap1 got=%b exp=0", ready); end
    access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, lows, res, err);
    total++;
    if (lows !== 5) begin bad++; $display("FAIL b2b_ld0_latency got=%0d exp=5", lows); end
    total++;
    if (res !== 32'h11) begin bad++; $display("FAIL b2b_ld0_data got=%h exp=11", res); end
    #1;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL b2b_gap2 got=%b exp=0", ready); end
    access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b1, lows, res, err);
    total++;
    if (lows !== 5) begin bad++; $display("FAIL b2b_ld1_latency got=%0d exp=5", lows); end
    total++;
    if (res !== 32'h22) begin bad++; $display("FAIL b2b_ld1_data got=%h exp=22", res); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    int lows; logic [31:0] res; logic err;
    access(1'b0, 1'b1, 32'd1036, 32'h12345678, 1'b1, lows, res, err);
    @(negedge clk);
    MEMwrite = 1'b1; address = 32'd1036; data = 32'h55;
    repeat (3) @(negedge clk);
    MEMwrite = 1'b0;
    #1;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL flush_in_access got=%b exp=0", ready); end
    @(negedge clk);
    #1;
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL flush_idle_ready got=%b exp=1", ready); end
    @(negedge clk);
    access(1'b1, 1'b0, 32'd1036, 32'h0, 1'b1, lows, res, err);
    total++;
    if (res !== 32'h12345678) begin bad++; $display("FAIL flush_old_data got=%h exp=12345678", res); end
    @(negedge clk);
  endtask

  task automatic test_bounds();
    int lows; logic [31:0] res; logic err;
    access(1'b1, 1'b0, 32'd1020, 32'h0, 1'b1, lows, res, err);
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL oob_rd_err got=%b exp=1", err); end
    total++;
    if (lows !== 5) begin bad++; $display("FAIL oob_rd_latency got=%0d exp=5", lows); end
    total++;
    if (res !== 32'd0) begin bad++; $display("FAIL oob_rd_data got=%h exp=0", res); end
    @(negedge clk);
    access(1'b0, 1'b1, 32'd1024 + 32'd256, 32'hBAD0BAD0, 1'b1, lows, res, err);
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL oob_wr_err got=%b exp=1", err); end
    @(negedge clk);
    access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1, lows, res, err);
    total++;
    if (res !== 32'h11) begin bad++; $display("FAIL oob_wr_word0 got=%h exp=11", res); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL inrange_err got=%b exp=0", err); end
    @(negedge clk);
    access(1'b1, 1'b0, 32'd1276, 32'h0, 1'b1, lows, res, err);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL last_word_err got=%b exp=0", err); end
    @(negedge clk);
  endtask

  task automatic test_rd_wr_both();
    int lows; logic [31:0] res; logic err;
    access(1'b1, 1'b1, 32'd1044, 32'h99, 1'b1, lows, res, err);
    total++;
    if (res !== 32'd0) begin bad++; $display("FAIL both_result got=%h exp=0", res); end
    @(negedge clk);
    access(1'b1, 1'b0, 32'd1044, 32'h0, 1'b1, lows, res, err);
    total++;
    if (res !== 32'h99) begin bad++; $display("FAIL both_stored got=%h exp=99", res); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int lows; logic [31:0] res; logic err;
    access(1'b0, 1'b1, 32'd1040, 32'h40404040, 1'b1, lows, res, err);
    @(negedge clk);
    MEMwrite = 1'b1; address = 32'd1040; data = 32'h77;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL arst_ready_req got=%b exp=0", ready); end
    total++;
    if (MEM_result !== 32'd0) begin bad++; $display("FAIL arst_result got=%h exp=0", MEM_result); end
    MEMwrite = 1'b0;
    #1;
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL arst_ready_noreq got=%b exp=1", ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    access(1'b1, 1'b0, 32'd1040, 32'h0, 1'b1, lows, res, err);
    total++;
    if (res !== 32'h40404040) begin bad++; $display("FAIL arst_storage got=%h exp=40404040", res); end
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_flush();
    test_bounds();
    test_rd_wr_both();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
